// File: rtl/unidade_load_store.sv
// rtl/unidade_load_store.sv - byte-addressed load/store unit over a 1-cycle synchronous word memory
// Optional build macro ADDR_RANGE_CHECK_EN rejects requests with nonzero address bits above the memory.
module unidade_load_store #(
    parameter int ADDR_W = 11
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] endereco,
    output logic [31:0]       writeData,
    input  logic [31:0]       readData
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STORE  = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    logic [2:0]        state_q, state_d;
    logic              store_q;
    logic [2:0]        op_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [ADDR_W-1:0] endereco_q;

    logic        accept;
    logic        op_legal;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign accept = req_valid && (state_q == S_IDLE);

    always_comb begin
        op_legal = 1'b0;
        case (req_op)
            OP_B, OP_H, OP_W: op_legal = 1'b1;
            OP_BU, OP_HU:     op_legal = !req_store;
            default:          op_legal = 1'b0;
        endcase
    end

    assign misaligned = ((req_op == OP_W) && (req_addr[1:0] != 2'b00)) ||
                        (((req_op == OP_H) || (req_op == OP_HU)) && req_addr[0]);

`ifdef ADDR_RANGE_CHECK_EN
    assign out_of_range = |req_addr[31:ADDR_W+2];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, req_addr[31:ADDR_W+2]};
    assign out_of_range   = 1'b0;
`endif

    assign req_err = !op_legal || misaligned || out_of_range;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)             state_d = S_RESP;
                    else if (!req_store)     state_d = S_LOAD;
                    else if (req_op == OP_W) state_d = S_STORE;
                    else                     state_d = S_RMW_RD;
                end
            end
            S_LOAD:   state_d = S_RESP;
            S_STORE:  state_d = S_RESP;
            S_RMW_RD: state_d = S_RMW_WR;
            S_RMW_WR: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            store_q    <= 1'b0;
            op_q       <= 3'b000;
            lane_q     <= 2'b00;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            endereco_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                store_q    <= req_store;
                op_q       <= req_op;
                lane_q     <= req_addr[1:0];
                wdata_q    <= req_wdata;
                err_q      <= req_err;
                endereco_q <= req_addr[ADDR_W+1:2];
            end
        end
    end

    // readData is only valid in the cycle after the read strobe, so the lane
    // extraction and the RMW merge are combinational on it rather than registered.
    assign lane_b = readData[8*lane_q +: 8];
    assign lane_h = readData[16*lane_q[1] +: 16];

    always_comb begin
        load_ext = 32'd0;
        case (op_q)
            OP_B:    load_ext = {{24{lane_b[7]}}, lane_b};
            OP_BU:   load_ext = {24'd0, lane_b};
            OP_H:    load_ext = {{16{lane_h[15]}}, lane_h};
            OP_HU:   load_ext = {16'd0, lane_h};
            OP_W:    load_ext = readData;
            default: load_ext = 32'd0;
        endcase
    end

    always_comb begin
        merged = readData;
        if (op_q == OP_B) merged[8*lane_q +: 8] = wdata_q[7:0];
        else              merged[16*lane_q[1] +: 16] = wdata_q[15:0];
    end

    always_comb begin
        writeData = 32'd0;
        case (state_q)
            S_STORE:  writeData = wdata_q;
            S_RMW_WR: writeData = merged;
            default:  writeData = 32'd0;
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = (state_q == S_RESP) && err_q;
    assign resp_rdata = ((state_q == S_RESP) && !store_q && !err_q) ? load_ext : 32'd0;
    assign MemRead    = (state_q == S_LOAD) || (state_q == S_RMW_RD);
    assign MemWrite   = (state_q == S_STORE) || (state_q == S_RMW_WR);
    assign endereco   = endereco_q;

endmodule

// File: tb/tb_unidade_load_store.sv
// tb/tb_unidade_load_store.sv - directed self-checking bench for unidade_load_store with a behavioural 2048x32 memory
module tb_unidade_load_store;
    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [10:0] endereco;
    logic [31:0] writeData;
    logic [31:0] readData;

    logic [31:0] mem [0:2047];
    logic        pre_we;
    logic [10:0] pre_addr;
    logic [31:0] pre_data;

    int tests;
    int fails;

    unidade_load_store #(.ADDR_W(11)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .endereco(endereco),
        .writeData(writeData), .readData(readData)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (MemWrite) mem[endereco] <= writeData;
        if (MemRead) readData <= mem[endereco];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request from IDLE and follows it to its response (bounded).
    task automatic do_req(input string tag, input logic st, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input int exp_rd, input int exp_wr, input logic [10:0] exp_idx);
        int lat;
        int nr;
        int nw;
        logic got;
        check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_store = st; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clock); #1;
        req_valid = 1'b0; req_store = ~st; req_op = 3'b111; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
        lat = 0; nr = 0; nw = 0; got = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (!got) begin
                if (MemRead) nr++;
                if (MemWrite) nw++;
                if (MemRead || MemWrite) check({tag, " endereco"}, {21'd0, endereco}, {21'd0, exp_idx});
                if (resp_valid) begin
                    got = 1'b1;
                    lat = i;
                    check({tag, " rdata"}, resp_rdata, exp_rdata);
                    check({tag, " err"}, {31'd0, resp_err}, {31'd0, exp_err});
                end else begin
                    @(posedge clock); #1;
                end
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " reads"}, nr, exp_rd);
        check({tag, " writes"}, nw, exp_wr);
        @(posedge clock); #1;
    endtask

    initial begin
        tests = 0; fails = 0;
        reset_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_op = 3'b000;
        req_addr = 32'd0; req_wdata = 32'd0;
        pre_we = 1'b1; pre_addr = 11'd5; pre_data = 32'h8899_AABB;
        repeat (2) @(posedge clock);
        #1;
        pre_we = 1'b0;
        check("rst ready", {31'd0, req_ready}, 32'd1);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst rdata", resp_rdata, 32'd0);
        check("rst err", {31'd0, resp_err}, 32'd0);
        check("rst strobes", {30'd0, MemRead, MemWrite}, 32'd0);
        check("rst endereco", {21'd0, endereco}, 32'd0);
        check("rst writeData", writeData, 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        do_req("LW 14",  1'b0, 3'b010, 32'h14, 32'd0, 32'h8899_AABB, 1'b0, 2, 1, 0, 11'd5);
        do_req("LB 16",  1'b0, 3'b000, 32'h16, 32'd0, 32'hFFFF_FF99, 1'b0, 2, 1, 0, 11'd5);
        do_req("LBU 16", 1'b0, 3'b100, 32'h16, 32'd0, 32'h0000_0099, 1'b0, 2, 1, 0, 11'd5);
        do_req("LH 16",  1'b0, 3'b001, 32'h16, 32'd0, 32'hFFFF_8899, 1'b0, 2, 1, 0, 11'd5);
        do_req("LHU 14", 1'b0, 3'b101, 32'h14, 32'd0, 32'h0000_AABB, 1'b0, 2, 1, 0, 11'd5);
        do_req("SB 15",  1'b1, 3'b000, 32'h15, 32'h1234_5677, 32'd0, 1'b0, 3, 1, 1, 11'd5);
        check("SB 15 mem", mem[5], 32'h8899_77BB);

        do_req("LW 16 misal",  1'b0, 3'b010, 32'h16, 32'd0, 32'd0, 1'b1, 1, 0, 0, 11'd0);
        do_req("SH 13 misal",  1'b1, 3'b001, 32'h13, 32'hFFFF, 32'd0, 1'b1, 1, 0, 0, 11'd0);
        do_req("L op011",      1'b0, 3'b011, 32'h14, 32'd0, 32'd0, 1'b1, 1, 0, 0, 11'd0);
        do_req("S op100",      1'b1, 3'b100, 32'h14, 32'hFF, 32'd0, 1'b1, 1, 0, 0, 11'd0);
        check("err mem intact", mem[5], 32'h8899_77BB);

        // Back-to-back with req_valid held high across both requests.
        req_valid = 1'b1; req_store = 1'b1; req_op = 3'b010; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        check("b2b busy0", {31'd0, req_ready}, 32'd0);
        req_store = 1'b0; req_wdata = 32'd0;
        check("b2b SW strobe", {30'd0, MemRead, MemWrite}, 32'd1);
        @(posedge clock); #1;
        check("b2b SW resp", {31'd0, resp_valid}, 32'd1);
        check("b2b busy1", {31'd0, req_ready}, 32'd0);
        @(posedge clock); #1;
        check("b2b idle", {31'd0, req_ready}, 32'd1);
        check("b2b no strobe", {30'd0, MemRead, MemWrite}, 32'd0);
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("b2b LW strobe", {30'd0, MemRead, MemWrite}, 32'd2);
        @(posedge clock); #1;
        check("b2b LW resp", {31'd0, resp_valid}, 32'd1);
        check("b2b LW rdata", resp_rdata, 32'hDEAD_BEEF);
        check("b2b mem", mem[8], 32'hDEAD_BEEF);
        @(posedge clock); #1;

        // Reset while the RMW read is in flight.
        req_valid = 1'b1; req_store = 1'b1; req_op = 3'b001; req_addr = 32'h14; req_wdata = 32'h0000_CAFE;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("rst rmw rd", {30'd0, MemRead, MemWrite}, 32'd2);
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        check("rst rmw ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("rst rmw quiet", {29'd0, resp_valid, MemRead, MemWrite}, 32'd0);
            @(posedge clock); #1;
        end
        check("rst rmw mem", mem[5], 32'h8899_77BB);

        do_req("SH 16",  1'b1, 3'b001, 32'h16, 32'h1111_BEEF, 32'd0, 1'b0, 3, 1, 1, 11'd5);
        check("SH 16 mem", mem[5], 32'hBEEF_77BB);
        do_req("LH 16b", 1'b0, 3'b001, 32'h16, 32'd0, 32'hFFFF_BEEF, 1'b0, 2, 1, 0, 11'd5);
`ifdef ADDR_RANGE_CHECK_EN
        do_req("LW 2014", 1'b0, 3'b010, 32'h0000_2014, 32'd0, 32'd0, 1'b1, 1, 0, 0, 11'd0);
`else
        do_req("LW 2014", 1'b0, 3'b010, 32'h0000_2014, 32'd0, 32'hBEEF_77BB, 1'b0, 2, 1, 0, 11'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/unidade_load_store.md
Name: unidade_load_store

Overview:
- Load/store unit between the pipeline MEM stage and the 2048×32 data memory (synchronous read and write, 1-cycle read latency, word-addressed).
- Converts byte-addressed requests into word accesses to the memory.
- Byte and halfword loads: extracts the lane and extends sign or zero.
- Byte and halfword stores: read-modify-write.
- Flags misaligned or illegal requests without touching memory.

Parameters:
- ADDR_W, 11, memory word-address width; the word index is req_addr[ADDR_W+1:2].

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit idle; a request is accepted at the edge where req_valid&&req_ready
- req_store  in  1  1 = store, 0 = load
- req_op  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse; no back-pressure
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  request rejected; valid only with resp_valid
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- endereco  out  ADDR_W  memory word address
- writeData  out  32  memory write data
- readData  in  32  memory read data, valid the cycle after a MemRead edge

Behaviour:
- Clock/reset:
  - One clock, named clock. Reset is reset_n, synchronous, active-low.
  - Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, MemRead=0, MemWrite=0, endereco=0, writeData=0.
- Lanes: little-endian.
  - Byte k of a word = bits [8k+7:8k], where k = req_addr[1:0].
  - Halfword at req_addr[1]=h occupies [16h+15:16h].
- Capture: req_store, req_op, req_addr, req_wdata are registered at accept; inputs may change afterwards.
- Errors: any of the following skips memory and goes directly to RESP with resp_err=1, resp_rdata=0:
  - req_op not in the legal set (stores accept only 000/001/010);
  - W with addr[1:0]≠0;
  - H/HU with addr[0]≠0.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- MemRead=1 exactly in LOAD and RMW_RD; MemWrite=1 exactly in STORE and RMW_WR. Both are decoded from the state register and are never asserted together.
- Transitions:
  - IDLE + accept → LOAD (load) | STORE (SW) | RMW_RD (SB/SH) | RESP (error).
  - LOAD → RESP. resp_rdata = extended lane of readData. B/H sign-extend; BU/HU zero-extend; W passes through.
  - STORE → RESP. writeData = captured wdata.
  - RMW_RD → RMW_WR. writeData = readData with the selected lane replaced by wdata[7:0] or wdata[15:0].
  - RMW_WR → RESP.
  - RESP → IDLE. resp_valid=1 for exactly this cycle.
- Latency (accept edge to resp_valid cycle): error 1, SW 2, load 2, SB/SH 3.
- req_ready=1 only in IDLE; at most one request in flight.
- endereco is held stable from the first strobe cycle through RESP.
- Upper address bits [31:ADDR_W+2] are ignored (aliasing) unless the optional feature is compiled in.
- Reset mid-operation:
  - A strobe asserted in the cycle where reset_n=0 is sampled still takes effect in memory at that edge, because the memory has no reset.
  - From the next cycle: no strobes, state IDLE, no resp_valid for the aborted request.
  - Reset in RMW_RD means no write ever occurs.

Optional Feature:
- ADDR_RANGE_CHECK_EN
  - Defined: a nonzero req_addr[31:ADDR_W+2] is an error (resp_err=1, 1-cycle latency, no strobe). Misalignment and illegal op are checked with equal priority; any one causes the error.
  - Undefined: upper bits are ignored and the access aliases into memory.

Test Plan:
- Reset, then word 5 = 0x8899AABB preloaded. LW addr 0x14 → MemRead once with endereco=5; resp_valid 2 cycles after accept; rdata=0x8899AABB, err=0.
- Loads from word 5:
  - LB addr 0x16 → 0xFFFFFF99.
  - LBU addr 0x16 → 0x00000099.
  - LH addr 0x16 → 0xFFFF8899.
  - LHU addr 0x14 → 0x0000AABB.
- SB addr 0x15, wdata 0x12345677 → MemRead then MemWrite on consecutive cycles; word 5 = 0x889977BB; resp 3 cycles after accept.
- Misalignment, each → resp_err=1 after 1 cycle, no MemRead/MemWrite ever asserted:
  - LW addr 0x16;
  - SH addr 0x13;
  - req_op=011 load.
- Back-to-back: req_valid held with SW addr 0x20 wdata 0xDEADBEEF then LW addr 0x20 → req_ready low while busy; second request accepted in the cycle after RESP; rdata=0xDEADBEEF.
- Reset: reset_n=0 during RMW_RD of SH addr 0x14 → word 5 unchanged, no resp_valid, req_ready=1 next cycle.
- With ADDR_RANGE_CHECK_EN: LW addr 0x00002014 → err=1, no strobe. Without: reads word 5.
